// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter fed by a circular byte FIFO (valid/ready input side).
// Latency: a byte pushed into an empty FIFO with the line idle drives the start bit from the next edge.
// Backpressure: data_ready drops when the FIFO is full, except on an edge that also pops a byte.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic                          done,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int                BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int                PTR_W      = $clog2(FIFO_DEPTH);
    localparam int                CNT_W      = PTR_W + 1;
    localparam logic [15:0]       BIT_LAST   = 16'(BIT_PERIOD - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             push;
    logic             pop;

    state_t           state;
    state_t           state_nxt;
    logic [15:0]      bit_cnt;
    logic [15:0]      bit_cnt_nxt;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_nxt;
    logic [7:0]       shift_dat;
    logic [7:0]       shift_nxt;
    logic             tx_nxt;
    logic             bit_end;

    // A pop frees a slot on the same edge, so a full FIFO still accepts then.
    assign fifo_empty = (fifo_count == '0);
    assign data_ready = (fifo_count != DEPTH_C) || pop;
    assign push       = data_valid && data_ready;
    assign tx_busy    = (state != IDLE);
    assign bit_end    = (bit_cnt == BIT_LAST);

    // Storage write; data_in is captured only here, so later changes do not touch queued bytes.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Frame state and datapath registers; reset abandons any frame and idles the line high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            shift_dat <= '0;
            tx        <= 1'b1;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            bit_idx   <= bit_idx_nxt;
            shift_dat <= shift_nxt;
            tx        <= tx_nxt;
        end
    end

    // Next-state, pop and done; STOP chains straight into START when more bytes wait.
    always_comb begin
        state_nxt   = state;
        bit_cnt_nxt = bit_cnt;
        bit_idx_nxt = bit_idx;
        shift_nxt   = shift_dat;
        tx_nxt      = tx;
        pop         = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                tx_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    shift_nxt   = mem[rd_ptr];
                    bit_cnt_nxt = '0;
                    tx_nxt      = 1'b0;
                    state_nxt   = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    tx_nxt      = shift_dat[0];
                    state_nxt   = DATA;
                end else begin
                    bit_cnt_nxt = bit_cnt + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_nxt = '0;
                    if (bit_idx == 3'd7) begin
                        tx_nxt    = 1'b1;
                        state_nxt = STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                        shift_nxt   = shift_dat >> 1;
                        tx_nxt      = shift_dat[1];
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    done        = 1'b1;
                    bit_cnt_nxt = '0;
                    if (!fifo_empty) begin
                        pop       = 1'b1;
                        shift_nxt = mem[rd_ptr];
                        tx_nxt    = 1'b0;
                        state_nxt = START;
                    end else begin
                        tx_nxt    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    bit_cnt_nxt = bit_cnt + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo with BIT_PERIOD = 10 clocks and an 8-entry FIFO.
// A line receiver decodes every frame from tx samples and records frame start and done cycles.
// Scenario tasks compare those records and live outputs against expectations built from byte queues.
module tb_uart_tx_fifo;

    logic       clk;
    logic       rst_n;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       tx_busy;
    logic       done;
    logic [3:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_byte_q[$];
    int         rx_start_q[$];
    bit         rx_err_q[$];
    int         done_cyc_q[$];
    logic [7:0] exp_q[$];
    int         kfill;

    logic       smp [100];
    int         rx_n;
    int         rx_start;
    bit         rx_active;

    uart_tx_fifo #(
        .CLK_FREQ   (1_000_000),
        .BAUD_RATE  (100_000),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .tx_busy    (tx_busy),
        .done       (done),
        .fifo_count (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line receiver: 100 samples per frame, every 10-sample bit window must be flat.
    initial begin
        logic [7:0] v;
        bit         e;
        rx_active = 1'b0;
        rx_n      = 0;
        rx_start  = 0;
        forever begin
            @(posedge clk);
            cyc++;
            #2;
            if (rst_n !== 1'b1) begin
                rx_active = 1'b0;
            end else begin
                if (done === 1'b1) done_cyc_q.push_back(cyc);
                if (!rx_active && tx === 1'b0) begin
                    rx_active = 1'b1;
                    rx_n      = 0;
                    rx_start  = cyc;
                end
                if (rx_active) begin
                    smp[rx_n] = tx;
                    rx_n++;
                    if (rx_n == 100) begin
                        e = 1'b0;
                        for (int b = 0; b < 10; b++)
                            for (int j = 1; j < 10; j++)
                                if (smp[b*10+j] !== smp[b*10]) e = 1'b1;
                        if (smp[0] !== 1'b0 || smp[90] !== 1'b1) e = 1'b1;
                        for (int b = 0; b < 8; b++) v[b] = smp[(b+1)*10];
                        rx_byte_q.push_back(v);
                        rx_start_q.push_back(rx_start);
                        rx_err_q.push_back(e);
                        rx_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_byte_q.delete();
        rx_start_q.delete();
        rx_err_q.delete();
        done_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        data_valid = 1'b0;
        data_in    = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) step();
        n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx: got %b want 1", tx); end
        n_checks++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        n_checks++; if (done !== 1'b0)       begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", data_ready); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_single_frame(input logic [7:0] b);
        int   k;
        int   bit_no;
        logic exp_tx;
        clear_rx();
        data_in    = b;
        data_valid = 1'b1;
        step();
        k          = cyc;
        data_valid = 1'b0;
        data_in    = ~b;
        n_checks++; if (fifo_count !== 4'd1) begin n_fail++; $display("FAIL single_count_push: got %0d want 1", fifo_count); end
        for (int i = 1; i <= 101; i++) begin
            step();
            bit_no = (i - 1) / 10;
            if (i > 100)          exp_tx = 1'b1;
            else if (bit_no == 0) exp_tx = 1'b0;
            else if (bit_no == 9) exp_tx = 1'b1;
            else                  exp_tx = b[bit_no-1];
            n_checks++; if (tx !== exp_tx) begin n_fail++; $display("FAIL single_tx c%0d: got %b want %b", i, tx, exp_tx); end
            n_checks++; if (tx_busy !== (i <= 100)) begin n_fail++; $display("FAIL single_busy c%0d: got %b want %b", i, tx_busy, (i <= 100)); end
            n_checks++; if (done !== (i == 100)) begin n_fail++; $display("FAIL single_done c%0d: got %b want %b", i, done, (i == 100)); end
        end
        n_checks++;
        if (rx_byte_q.size() != 1) begin
            n_fail++; $display("FAIL single_rx_frames: got %0d want 1", rx_byte_q.size());
        end else if (rx_byte_q[0] !== b || rx_err_q[0] || rx_start_q[0] != k + 1) begin
            n_fail++; $display("FAIL single_rx: got %h err %0d start %0d want %h err 0 start %0d",
                               rx_byte_q[0], rx_err_q[0], rx_start_q[0], b, k + 1);
        end
    endtask

    task automatic test_back_to_back();
        int k;
        clear_rx();
        data_in    = 8'h00;
        data_valid = 1'b1;
        step();
        k          = cyc;
        data_in    = 8'hFF;
        step();
        data_valid = 1'b0;
        data_in    = 8'($urandom);
        for (int i = 1; i <= 205; i++) begin
            if (i > 1) step();
            n_checks++; if (tx_busy !== (i <= 200)) begin n_fail++; $display("FAIL b2b_busy c%0d: got %b want %b", i, tx_busy, (i <= 200)); end
        end
        n_checks++;
        if (rx_byte_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_frames: got %0d want 2", rx_byte_q.size());
        end else if (rx_byte_q[0] !== 8'h00 || rx_byte_q[1] !== 8'hFF || rx_err_q[0] || rx_err_q[1]
                     || rx_start_q[0] != k + 1 || rx_start_q[1] != k + 101) begin
            n_fail++; $display("FAIL b2b_rx: got %h@%0d %h@%0d want 00@%0d ff@%0d",
                               rx_byte_q[0], rx_start_q[0], rx_byte_q[1], rx_start_q[1], k + 1, k + 101);
        end
        n_checks++;
        if (done_cyc_q.size() != 2) begin
            n_fail++; $display("FAIL b2b_done_count: got %0d want 2", done_cyc_q.size());
        end else if (done_cyc_q[0] != k + 100 || done_cyc_q[1] - done_cyc_q[0] != 100) begin
            n_fail++; $display("FAIL b2b_done_cycles: got %0d,%0d want %0d,%0d",
                               done_cyc_q[0], done_cyc_q[1], k + 100, k + 200);
        end
    endtask

    task automatic test_random_burst();
        int k;
        int n;
        int gap;
        int exp_cnt;
        clear_rx();
        exp_q.delete();
        n = $urandom_range(2, 9);
        k = 0;
        for (int j = 0; j < n; j++) begin
            gap = (j == 0) ? 0 : $urandom_range(0, 3);
            repeat (gap) begin
                data_in = 8'($urandom);
                step();
            end
            n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL burst_ready j%0d: got %b want 1", j, data_ready); end
            data_in    = 8'($urandom);
            data_valid = 1'b1;
            exp_q.push_back(data_in);
            step();
            if (j == 0) k = cyc;
            data_valid = 1'b0;
            data_in    = 8'($urandom);
            exp_cnt    = (j == 0) ? 1 : j;
            n_checks++; if (fifo_count !== 4'(exp_cnt)) begin n_fail++; $display("FAIL burst_count j%0d: got %0d want %0d", j, fifo_count, exp_cnt); end
        end
        while (cyc < k + 100 * n + 2) step();
        n_checks++;
        if (rx_byte_q.size() != n) begin
            n_fail++; $display("FAIL burst_frames: got %0d want %0d", rx_byte_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (rx_byte_q[i] !== exp_q[i] || rx_err_q[i] || rx_start_q[i] != k + 1 + 100 * i) begin
                    n_fail++; $display("FAIL burst_rx%0d: got %h@%0d err %0d want %h@%0d",
                                       i, rx_byte_q[i], rx_start_q[i], rx_err_q[i], exp_q[i], k + 1 + 100 * i);
                end
            end
        end
        n_checks++; if (done_cyc_q.size() != n) begin n_fail++; $display("FAIL burst_done_count: got %0d want %0d", done_cyc_q.size(), n); end
    endtask

    task automatic test_fill_and_reject();
        int occ;
        bit pop_now;
        bit ready_exp;
        clear_rx();
        exp_q.delete();
        occ   = 0;
        kfill = 0;
        for (int j = 0; j < 12; j++) begin
            data_in    = 8'(j + 1);
            data_valid = 1'b1;
            pop_now    = (j == 1);
            ready_exp  = (occ < 8) || pop_now;
            n_checks++; if (data_ready !== ready_exp) begin n_fail++; $display("FAIL fill_ready j%0d: got %b want %b", j, data_ready, ready_exp); end
            if (ready_exp) begin
                exp_q.push_back(data_in);
                occ++;
            end
            if (pop_now) occ--;
            step();
            if (j == 0) kfill = cyc;
            n_checks++; if (fifo_count !== 4'(occ)) begin n_fail++; $display("FAIL fill_count j%0d: got %0d want %0d", j, fifo_count, occ); end
        end
        data_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL fill_full: got %0d want 8", fifo_count); end
        n_checks++; if (exp_q.size() != 9) begin n_fail++; $display("FAIL fill_accepted: got %0d want 9", exp_q.size()); end
    endtask

    task automatic test_full_pop_edge();
        bit found;
        found = 1'b0;
        n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL fullpop_ready_before: got %b want 0", data_ready); end
        for (int i = 0; i < 200 && !found; i++) begin
            step();
            if (done === 1'b1) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++; $display("FAIL fullpop_wait: got no done within 200 cycles want done");
        end else begin
            n_checks++; if (cyc != kfill + 100) begin n_fail++; $display("FAIL fullpop_done_cycle: got %0d want %0d", cyc, kfill + 100); end
            data_in    = 8'h55;
            data_valid = 1'b1;
            n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL fullpop_ready: got %b want 1", data_ready); end
            exp_q.push_back(8'h55);
            step();
            data_valid = 1'b0;
            data_in    = 8'($urandom);
            n_checks++; if (fifo_count !== 4'd8) begin n_fail++; $display("FAIL fullpop_count: got %0d want 8", fifo_count); end
        end
    endtask

    task automatic test_drain();
        int n;
        n = exp_q.size();
        while (cyc < kfill + 100 * n + 2) step();
        n_checks++;
        if (rx_byte_q.size() != n) begin
            n_fail++; $display("FAIL drain_frames: got %0d want %0d", rx_byte_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (rx_byte_q[i] !== exp_q[i] || rx_err_q[i] || rx_start_q[i] != kfill + 1 + 100 * i) begin
                    n_fail++; $display("FAIL drain_rx%0d: got %h@%0d err %0d want %h@%0d",
                                       i, rx_byte_q[i], rx_start_q[i], rx_err_q[i], exp_q[i], kfill + 1 + 100 * i);
                end
            end
        end
        n_checks++; if (done_cyc_q.size() != n) begin n_fail++; $display("FAIL drain_done_count: got %0d want %0d", done_cyc_q.size(), n); end
        n_checks++; if (fifo_count !== 4'd0 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got count %0d busy %b want 0 0", fifo_count, tx_busy); end
    endtask

    task automatic test_reset_mid_frame();
        int         k;
        logic [7:0] first;
        logic [7:0] nb;
        clear_rx();
        first      = 8'h3C;
        data_in    = first;
        data_valid = 1'b1;
        step();
        k = cyc;
        for (int j = 0; j < 4; j++) begin
            data_in = 8'($urandom);
            step();
        end
        data_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd4) begin n_fail++; $display("FAIL rstmid_queued: got %0d want 4", fifo_count); end
        while (cyc < k + 45) step();
        n_checks++; if (tx !== first[3]) begin n_fail++; $display("FAIL rstmid_bit3: got %b want %b", tx, first[3]); end
        rst_n = 1'b0;
        #1;
        n_checks++; if (tx !== 1'b1)         begin n_fail++; $display("FAIL rstmid_tx: got %b want 1", tx); end
        n_checks++; if (fifo_count !== 4'd0) begin n_fail++; $display("FAIL rstmid_count: got %0d want 0", fifo_count); end
        n_checks++; if (tx_busy !== 1'b0)    begin n_fail++; $display("FAIL rstmid_busy: got %b want 0", tx_busy); end
        n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", data_ready); end
        repeat (3) begin
            step();
            n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rstmid_done: got %b want 0", done); end
        end
        rst_n = 1'b1;
        for (int i = 0; i < 150; i++) begin
            step();
            n_checks++; if (tx !== 1'b1 || tx_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle c%0d: got tx %b busy %b want 1 0", i, tx, tx_busy); end
        end
        n_checks++; if (rx_byte_q.size() != 0 || done_cyc_q.size() != 0) begin n_fail++; $display("FAIL rstmid_no_frames: got %0d frames %0d done want 0 0", rx_byte_q.size(), done_cyc_q.size()); end
        nb         = 8'($urandom);
        data_in    = nb;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        repeat (102) step();
        n_checks++;
        if (rx_byte_q.size() != 1) begin
            n_fail++; $display("FAIL rstmid_after_frames: got %0d want 1", rx_byte_q.size());
        end else if (rx_byte_q[0] !== nb || rx_err_q[0]) begin
            n_fail++; $display("FAIL rstmid_after_rx: got %h err %0d want %h err 0", rx_byte_q[0], rx_err_q[0], nb);
        end
    endtask

    initial begin
        test_reset();
        test_single_frame(8'hA5);
        test_single_frame(8'($urandom));
        test_back_to_back();
        repeat (3) test_random_burst();
        test_fill_and_reject();
        test_full_pop_edge();
        test_drain();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
